// File: rtl/reg_op_sequencer_pkg.sv
// Shared types for the register/ALU operation sequencer: opcodes, ALU modes and FSM states.
// The package keeps the name BusTypes so existing control-unit code can import it unchanged.
package BusTypes;

    typedef enum logic [3:0] {
        OP_CMOV = 4'd0,
        OP_ADD  = 4'd3,
        OP_MUL  = 4'd4,
        OP_DIV  = 4'd5,
        OP_NAND = 4'd6
    } opcode_e;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_MUL  = 2'b01;
    localparam logic [1:0] ALU_DIV  = 2'b10;
    localparam logic [1:0] ALU_NAND = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_B,
        S_RD_C,
        S_EXEC,
        S_WRITE_A,
        S_DONE,
        S_FAULT
    } seq_state_e;

    function automatic logic [1:0] alu_mode_of(input logic [3:0] op);
        case (op)
            OP_MUL:  alu_mode_of = ALU_MUL;
            OP_DIV:  alu_mode_of = ALU_DIV;
            OP_NAND: alu_mode_of = ALU_NAND;
            default: alu_mode_of = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/reg_op_sequencer_rd_wait_counter.sv
// Clearable up-counter with a terminal-count flag; times both register reads and the ALU watchdog.
module rd_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = enable && (count == terminal);

endmodule

// File: rtl/reg_op_sequencer.sv
// Sequencer for cmov/add/mul/div/nand between the control unit, the register file and a multi-cycle ALU.
// All outputs are registered; they are set on the transition into the state that owns them.
module reg_op_sequencer
    import BusTypes::*;
#(
    parameter int WIDTH       = 32,
    parameter int REG_SEL_W   = 3,
    parameter int REG_RD_LAT  = 1,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic                 start,
    input  logic [3:0]           opcode,
    input  logic [REG_SEL_W-1:0] reg_a,
    input  logic [REG_SEL_W-1:0] reg_b,
    input  logic [REG_SEL_W-1:0] reg_c,
    input  logic [WIDTH-1:0]     reg_rdata,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 reg_we,
    output logic [WIDTH-1:0]     reg_wdata,
    output logic [WIDTH-1:0]     alu_x,
    output logic [WIDTH-1:0]     alu_y,
    output logic [1:0]           alu_mode,
    output logic                 alu_req,
    input  logic                 alu_ack,
    input  logic [WIDTH-1:0]     alu_result,
    output logic                 busy,
    output logic                 done,
    output logic                 fault
);

    localparam int CNT_MAX = (ALU_TIMEOUT > REG_RD_LAT) ? ALU_TIMEOUT : REG_RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_e           state;
    logic [3:0]           op_q;
    logic [REG_SEL_W-1:0] a_q;
    logic [REG_SEL_W-1:0] b_q;
    logic [REG_SEL_W-1:0] c_q;
    logic [WIDTH-1:0]     b_val;

    logic             cnt_en;
    logic             cnt_clr;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_term;
    logic [CNT_W-1:0] cnt_val;

    // The counter restarts whenever the current state is left, so each read or EXEC starts at zero.
    assign cnt_en   = (state == S_RD_B) || (state == S_RD_C) || (state == S_EXEC);
    assign cnt_clr  = !cnt_en || cnt_tc || ((state == S_EXEC) && alu_ack);
    assign cnt_term = (state == S_EXEC) ? CNT_W'(ALU_TIMEOUT - 1) : CNT_W'(REG_RD_LAT);

    rd_wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait (
        .clk     (clk),
        .init_n  (init_n),
        .clear   (cnt_clr),
        .enable  (cnt_en),
        .terminal(cnt_term),
        .count   (cnt_val),
        .tc      (cnt_tc)
    );

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            b_val     <= '0;
            reg_sel   <= '0;
            reg_we    <= 1'b0;
            reg_wdata <= '0;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_mode  <= '0;
            alu_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            done   <= 1'b0;
            fault  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= opcode;
                        a_q  <= reg_a;
                        b_q  <= reg_b;
                        c_q  <= reg_c;
                        busy <= 1'b1;
                        case (opcode)
                            OP_CMOV: begin
                                state   <= S_RD_C;
                                reg_sel <= reg_c;
                            end
                            OP_ADD, OP_MUL, OP_DIV, OP_NAND: begin
                                state   <= S_RD_B;
                                reg_sel <= reg_b;
                            end
                            default: begin
                                state <= S_FAULT;
                                done  <= 1'b1;
                                fault <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD_B: begin
                    if (cnt_tc) begin
                        b_val <= reg_rdata;
                        if (op_q == OP_CMOV) begin
                            state     <= S_WRITE_A;
                            reg_sel   <= a_q;
                            reg_we    <= 1'b1;
                            reg_wdata <= reg_rdata;
                        end else begin
                            state   <= S_RD_C;
                            reg_sel <= c_q;
                        end
                    end
                end
                S_RD_C: begin
                    if (cnt_tc) begin
                        if (op_q == OP_CMOV) begin
                            if (reg_rdata == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state   <= S_RD_B;
                                reg_sel <= b_q;
                            end
                        end else if ((op_q == OP_DIV) && (reg_rdata == '0)) begin
                            state <= S_FAULT;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state    <= S_EXEC;
                            alu_req  <= 1'b1;
                            alu_x    <= b_val;
                            alu_y    <= reg_rdata;
                            alu_mode <= alu_mode_of(op_q);
                        end
                    end
                end
                S_EXEC: begin
                    if (alu_ack) begin
                        state     <= S_WRITE_A;
                        alu_req   <= 1'b0;
                        reg_sel   <= a_q;
                        reg_we    <= 1'b1;
                        reg_wdata <= alu_result;
                    end else if (cnt_tc) begin
                        state   <= S_FAULT;
                        alu_req <= 1'b0;
                        done    <= 1'b1;
                        fault   <= 1'b1;
                    end
                end
                S_WRITE_A: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE, S_FAULT: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench: d1 instance uses default latency/timeout, d3 uses REG_RD_LAT=3 and ALU_TIMEOUT=4.
module tb_reg_op_sequencer;
    import BusTypes::*;

    logic clk;
    logic init_n;
    int   errors;
    int   checks;

    logic        d1_start, d1_alu_ack, d1_reg_we, d1_alu_req, d1_busy, d1_done, d1_fault;
    logic [3:0]  d1_opcode;
    logic [2:0]  d1_ra, d1_rb, d1_rc, d1_reg_sel, d1_sel_q;
    logic [31:0] d1_reg_rdata, d1_reg_wdata, d1_alu_x, d1_alu_y, d1_alu_result;
    logic [1:0]  d1_alu_mode;
    logic [31:0] d1_regs [8];
    int          d1_we_cnt;

    logic        d3_start, d3_alu_ack, d3_reg_we, d3_alu_req, d3_busy, d3_done, d3_fault;
    logic [3:0]  d3_opcode;
    logic [2:0]  d3_ra, d3_rb, d3_rc, d3_reg_sel, d3_sel_p1, d3_sel_p2, d3_sel_p3;
    logic [31:0] d3_reg_rdata, d3_reg_wdata, d3_alu_x, d3_alu_y, d3_alu_result;
    logic [1:0]  d3_alu_mode;
    logic [31:0] d3_regs [8];
    int          d3_we_cnt;

    int we0;

    reg_op_sequencer #(.WIDTH(32), .REG_SEL_W(3), .REG_RD_LAT(1), .ALU_TIMEOUT(64)) dut_d1 (
        .clk(clk), .init_n(init_n), .start(d1_start), .opcode(d1_opcode),
        .reg_a(d1_ra), .reg_b(d1_rb), .reg_c(d1_rc), .reg_rdata(d1_reg_rdata),
        .reg_sel(d1_reg_sel), .reg_we(d1_reg_we), .reg_wdata(d1_reg_wdata),
        .alu_x(d1_alu_x), .alu_y(d1_alu_y), .alu_mode(d1_alu_mode), .alu_req(d1_alu_req),
        .alu_ack(d1_alu_ack), .alu_result(d1_alu_result),
        .busy(d1_busy), .done(d1_done), .fault(d1_fault)
    );

    reg_op_sequencer #(.WIDTH(32), .REG_SEL_W(3), .REG_RD_LAT(3), .ALU_TIMEOUT(4)) dut_d3 (
        .clk(clk), .init_n(init_n), .start(d3_start), .opcode(d3_opcode),
        .reg_a(d3_ra), .reg_b(d3_rb), .reg_c(d3_rc), .reg_rdata(d3_reg_rdata),
        .reg_sel(d3_reg_sel), .reg_we(d3_reg_we), .reg_wdata(d3_reg_wdata),
        .alu_x(d3_alu_x), .alu_y(d3_alu_y), .alu_mode(d3_alu_mode), .alu_req(d3_alu_req),
        .alu_ack(d3_alu_ack), .alu_result(d3_alu_result),
        .busy(d3_busy), .done(d3_done), .fault(d3_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file models: data appears REG_RD_LAT clocks after the address.
    always @(posedge clk) begin
        d1_sel_q  <= d1_reg_sel;
        d3_sel_p1 <= d3_reg_sel;
        d3_sel_p2 <= d3_sel_p1;
        d3_sel_p3 <= d3_sel_p2;
        if (d1_reg_we === 1'b1) d1_we_cnt++;
        if (d3_reg_we === 1'b1) d3_we_cnt++;
    end
    assign d1_reg_rdata = d1_regs[d1_sel_q];
    assign d3_reg_rdata = d3_regs[d3_sel_p3];

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_d1(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        d1_start = 1'b1; d1_opcode = op; d1_ra = a; d1_rb = b; d1_rc = c;
        step_n(1);
        d1_start = 1'b0;
    endtask

    task automatic start_d3(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        d3_start = 1'b1; d3_opcode = op; d3_ra = a; d3_rb = b; d3_rc = c;
        step_n(1);
        d3_start = 1'b0;
    endtask

    initial begin
        errors = 0; checks = 0; d1_we_cnt = 0; d3_we_cnt = 0;
        init_n = 1'b0;
        d1_start = 0; d1_opcode = 0; d1_ra = 0; d1_rb = 0; d1_rc = 0; d1_alu_ack = 0; d1_alu_result = 0;
        d3_start = 0; d3_opcode = 0; d3_ra = 0; d3_rb = 0; d3_rc = 0; d3_alu_ack = 0; d3_alu_result = 0;
        for (int i = 0; i < 8; i++) begin
            d1_regs[i] = 32'h0;
            d3_regs[i] = 32'h0;
        end
        d1_regs[1] = 32'hDEADBEEF; d1_regs[2] = 32'd7; d1_regs[3] = 32'd5; d1_regs[5] = 32'd100;
        d3_regs[0] = 32'h11; d3_regs[1] = 32'h99; d3_regs[2] = 32'h22; d3_regs[3] = 32'h33;

        step_n(2);
        check_output("rst_busy", d1_busy, 0);
        check_output("rst_done", d1_done, 0);
        check_output("rst_req", d1_alu_req, 0);
        check_output("rst_we", d1_reg_we, 0);
        check_output("rst_wdata", d1_reg_wdata, 0);
        check_output("rst_d3_busy", d3_busy, 0);
        init_n = 1'b1;
        step_n(2);

        $display("[TB] add r1=r2+r3, immediate ack");
        start_d1(OP_ADD, 3'd1, 3'd2, 3'd3);
        check_output("add_busy_c1", d1_busy, 1);
        step_n(3);
        check_output("add_req_c4", d1_alu_req, 0);
        step_n(1);
        check_output("add_req_c5", d1_alu_req, 1);
        check_output("add_x", d1_alu_x, 7);
        check_output("add_y", d1_alu_y, 5);
        check_output("add_mode", d1_alu_mode, 2'b00);
        d1_alu_ack = 1; d1_alu_result = 32'd12;
        step_n(1);
        d1_alu_ack = 0;
        check_output("add_we_c6", d1_reg_we, 1);
        check_output("add_sel", d1_reg_sel, 1);
        check_output("add_wdata", d1_reg_wdata, 12);
        check_output("add_req_off", d1_alu_req, 0);
        step_n(1);
        check_output("add_done_c7", d1_done, 1);
        check_output("add_fault_c7", d1_fault, 0);
        check_output("add_we_off", d1_reg_we, 0);
        step_n(1);
        check_output("add_idle", d1_busy, 0);
        check_output("add_done_off", d1_done, 0);

        $display("[TB] div by zero, ack held high outside EXEC");
        we0 = d1_we_cnt;
        d1_alu_ack = 1;
        start_d1(OP_DIV, 3'd4, 3'd5, 3'd6);
        step_n(4);
        check_output("div0_done", d1_done, 1);
        check_output("div0_fault", d1_fault, 1);
        check_output("div0_req", d1_alu_req, 0);
        d1_alu_ack = 0;
        step_n(1);
        check_output("div0_idle", d1_busy, 0);
        check_output("div0_no_write", d1_we_cnt, we0);

        $display("[TB] illegal opcode");
        start_d1(4'd2, 3'd1, 3'd2, 3'd3);
        check_output("badop_done", d1_done, 1);
        check_output("badop_fault", d1_fault, 1);
        step_n(1);
        check_output("badop_idle", d1_busy, 0);

        $display("[TB] cmov with zero then nonzero condition");
        d1_regs[2] = 32'd0;
        we0 = d1_we_cnt;
        start_d1(OP_CMOV, 3'd0, 3'd1, 3'd2);
        step_n(2);
        check_output("cmov0_done_c3", d1_done, 1);
        check_output("cmov0_fault", d1_fault, 0);
        check_output("cmov0_no_write", d1_we_cnt, we0);
        step_n(1);
        d1_regs[2] = 32'd9;
        start_d1(OP_CMOV, 3'd0, 3'd1, 3'd2);
        step_n(4);
        check_output("cmov_we_c5", d1_reg_we, 1);
        check_output("cmov_sel", d1_reg_sel, 0);
        check_output("cmov_wdata", d1_reg_wdata, 32'hDEADBEEF);
        step_n(1);
        check_output("cmov_done_c6", d1_done, 1);
        check_output("cmov_fault_c6", d1_fault, 0);
        step_n(1);

        $display("[TB] mul with ack delayed 10 cycles");
        start_d1(OP_MUL, 3'd7, 3'd2, 3'd3);
        step_n(4);
        for (int i = 0; i < 10; i++) begin
            check_output("mul_req_held", d1_alu_req, 1);
            check_output("mul_x_stable", d1_alu_x, 9);
            check_output("mul_y_stable", d1_alu_y, 5);
            step_n(1);
        end
        check_output("mul_mode", d1_alu_mode, 2'b01);
        d1_alu_ack = 1; d1_alu_result = 32'd45;
        step_n(1);
        d1_alu_ack = 0;
        check_output("mul_we", d1_reg_we, 1);
        check_output("mul_sel", d1_reg_sel, 7);
        check_output("mul_wdata", d1_reg_wdata, 45);
        step_n(1);
        check_output("mul_done", d1_done, 1);
        step_n(1);

        $display("[TB] reset pulses during EXEC and WRITE_A");
        we0 = d1_we_cnt;
        start_d1(OP_ADD, 3'd1, 3'd2, 3'd3);
        step_n(4);
        check_output("rexec_req_before", d1_alu_req, 1);
        #2 init_n = 1'b0;
        #1;
        check_output("rexec_req", d1_alu_req, 0);
        check_output("rexec_busy", d1_busy, 0);
        check_output("rexec_x", d1_alu_x, 0);
        init_n = 1'b1;
        step_n(1);
        start_d1(OP_ADD, 3'd1, 3'd2, 3'd3);
        step_n(4);
        d1_alu_ack = 1; d1_alu_result = 32'd14;
        step_n(1);
        d1_alu_ack = 0;
        check_output("rwr_we_before", d1_reg_we, 1);
        #2 init_n = 1'b0;
        #1;
        check_output("rwr_we", d1_reg_we, 0);
        check_output("rwr_busy", d1_busy, 0);
        check_output("rwr_sel", d1_reg_sel, 0);
        init_n = 1'b1;
        step_n(1);
        check_output("rst_no_write", d1_we_cnt, we0);
        start_d1(OP_ADD, 3'd1, 3'd2, 3'd3);
        step_n(4);
        check_output("clean_req", d1_alu_req, 1);
        d1_alu_ack = 1; d1_alu_result = 32'd14;
        step_n(1);
        d1_alu_ack = 0;
        check_output("clean_we", d1_reg_we, 1);
        check_output("clean_wdata", d1_reg_wdata, 14);
        step_n(1);
        check_output("clean_done", d1_done, 1);
        check_output("clean_fault", d1_fault, 0);
        step_n(1);

        $display("[TB] start held high while busy");
        we0 = d1_we_cnt;
        d1_start = 1; d1_opcode = OP_CMOV; d1_ra = 3'd0; d1_rb = 3'd1; d1_rc = 3'd2;
        step_n(5);
        check_output("hold_we_c5", d1_reg_we, 1);
        step_n(1);
        check_output("hold_done_c6", d1_done, 1);
        d1_start = 0;
        step_n(3);
        check_output("hold_one_write", d1_we_cnt, we0 + 1);
        check_output("hold_idle", d1_busy, 0);

        $display("[TB] REG_RD_LAT=3 add");
        start_d3(OP_ADD, 3'd1, 3'd2, 3'd3);
        step_n(3);
        check_output("lat3_busy_c4", d3_busy, 1);
        step_n(4);
        check_output("lat3_req_c8", d3_alu_req, 0);
        step_n(1);
        check_output("lat3_req_c9", d3_alu_req, 1);
        check_output("lat3_x", d3_alu_x, 32'h22);
        check_output("lat3_y", d3_alu_y, 32'h33);
        d3_alu_ack = 1; d3_alu_result = 32'h55;
        step_n(1);
        d3_alu_ack = 0;
        check_output("lat3_we", d3_reg_we, 1);
        check_output("lat3_sel", d3_reg_sel, 1);
        check_output("lat3_wdata", d3_reg_wdata, 32'h55);
        step_n(1);
        check_output("lat3_done", d3_done, 1);
        step_n(1);

        $display("[TB] ALU_TIMEOUT=4 never-ack mul");
        we0 = d3_we_cnt;
        start_d3(OP_MUL, 3'd4, 3'd2, 3'd3);
        step_n(8);
        check_output("to_req_c9", d3_alu_req, 1);
        check_output("to_mode", d3_alu_mode, 2'b01);
        step_n(3);
        check_output("to_req_c12", d3_alu_req, 1);
        check_output("to_done_c12", d3_done, 0);
        step_n(1);
        check_output("to_done", d3_done, 1);
        check_output("to_fault", d3_fault, 1);
        check_output("to_req_drop", d3_alu_req, 0);
        step_n(1);
        check_output("to_idle", d3_busy, 0);
        check_output("to_no_write", d3_we_cnt, we0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
